// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared types and defaults for the systolic-array drain logic.
// Revision : 1.0  initial release
// ============================================================================
package tpu_pkg;

  // Default accumulator width and array dimension
  localparam int c_bits_c = 16;
  localparam int c_dim    = 8;

  // Drain controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

  // Row index width; a single-row array still needs a 1-bit index port
  function automatic int idx_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Counter width: must be able to hold the value DIM itself
  function automatic int cnt_width(input int dim);
    return $clog2(dim) + 1;
  endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tpu_row_buf.sv
`default_nettype none
// ============================================================================
// Module   : tpu_row_buf
// Purpose  : One-entry valid/ready output register. Accepts a new word when
//            empty or when the current word is being consumed this cycle.
// Revision : 1.0  initial release
// ============================================================================
module tpu_row_buf
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_req,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_can_load,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot is free when empty or when the held word leaves on this edge
  always_comb begin
    o_can_load = !valid_q || i_ready;
  end

  // Next-state: reload keeps valid high, a bare handshake empties the slot
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_load_req && o_can_load) begin
      data_d  = i_load_data;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule : tpu_row_buf
`default_nettype wire

// File: rtl/tpu_c_drain.sv
`default_nettype none
// ============================================================================
// Module   : tpu_c_drain
// Purpose  : Unload controller for the systolic MAC array. Shifts accumulated
//            C results down one row per step, captures the bottom row and
//            streams rows out bottom-first on a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module tpu_c_drain
  import tpu_pkg::*;
#(
  parameter int BITS_C = c_bits_c,
  parameter int DIM    = c_dim
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM*BITS_C-1:0]     c_in,
  output logic                      arr_en,
  output logic                      arr_wren,
  output logic [DIM*BITS_C-1:0]     row_data,
  output logic [idx_width(DIM)-1:0] row_idx,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int c_cnt_w = cnt_width(DIM);
  localparam int c_idx_w = idx_width(DIM);
  localparam int c_row_w = DIM * BITS_C;
  localparam int c_buf_w = c_idx_w + c_row_w;

  localparam logic [c_cnt_w-1:0] c_dim_cnt  = c_cnt_w'(DIM);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(DIM - 1);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

  drain_state_t       state_q, state_d;
  logic [c_cnt_w-1:0] cap_cnt_q, cap_cnt_d;
  logic [c_cnt_w-1:0] sent_cnt_q, sent_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_can_load;
  logic               w_step;
  logic               w_handshake;
  logic [c_cnt_w-1:0] w_idx_full;
  logic [c_idx_w-1:0] w_idx_next;
  logic [c_buf_w-1:0] w_buf_out;

  // Step when rows remain to capture and the output slot can take one;
  // the array shifts on exactly the edges where a row is captured
  always_comb begin
    w_handshake = row_valid && row_ready;
    w_step      = (state_q == ST_DRAIN) && (cap_cnt_q < c_dim_cnt) && w_can_load;
    arr_en      = w_step;
    arr_wren    = w_step;
  end

  // Bottom row leaves first, so the index counts down from DIM-1
  always_comb begin
    w_idx_full = c_last_idx - cap_cnt_q;
    w_idx_next = w_idx_full[c_idx_w-1:0];
  end

  tpu_row_buf #(
    .WIDTH (c_buf_w)
  ) u_row_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load_req  (w_step),
    .i_load_data ({w_idx_next, c_in}),
    .o_can_load  (w_can_load),
    .o_data      (w_buf_out),
    .o_valid     (row_valid),
    .i_ready     (row_ready)
  );

  assign row_idx  = w_buf_out[c_buf_w-1 -: c_idx_w];
  assign row_data = w_buf_out[c_row_w-1:0];

  // Control next-state: counters clear on an accepted start, DONE after
  // the DIM-th handshake, DONE always returns to IDLE after one cycle
  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    sent_cnt_d = sent_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRAIN;
          cap_cnt_d  = '0;
          sent_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (w_step) begin
          cap_cnt_d = cap_cnt_q + c_one;
        end
        if (w_handshake) begin
          sent_cnt_d = sent_cnt_q + c_one;
          if (sent_cnt_d == c_dim_cnt) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_cnt_q  <= '0;
      sent_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_cnt_q  <= cap_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule : tpu_c_drain
`default_nettype wire

// File: tb/tb_tpu_c_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_c_drain
// Purpose  : Self-checking bench for tpu_c_drain with a behavioural array
//            model and a row scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_tpu_c_drain;

  localparam int DIM = 4;
  localparam int BW  = 16;
  localparam int RW  = DIM * BW;

  logic          clk = 1'b0;
  logic          rst, start, row_ready;
  logic [RW-1:0] c_in, row_data;
  logic [1:0]    row_idx;
  logic          arr_en, arr_wren, row_valid, busy, done;

  always #5 clk = ~clk;

  tpu_c_drain #(.BITS_C(BW), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .c_in(c_in),
    .arr_en(arr_en), .arr_wren(arr_wren), .row_data(row_data),
    .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .done(done)
  );

  // Array model: arr[r][j], row DIM-1 at the bottom feeding c_in
  logic [BW-1:0] arr      [DIM][DIM];
  logic [BW-1:0] load_val [DIM][DIM];
  logic          load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < DIM; r++)
        for (int j = 0; j < DIM; j++) arr[r][j] <= load_val[r][j];
    end else if (arr_en && arr_wren) begin
      for (int r = DIM - 1; r > 0; r--)
        for (int j = 0; j < DIM; j++) arr[r][j] <= arr[r-1][j];
      for (int j = 0; j < DIM; j++) arr[0][j] <= '0;
    end
  end

  always_comb begin
    c_in = '0;
    for (int j = 0; j < DIM; j++) c_in[j*BW +: BW] = arr[DIM-1][j];
  end

  typedef struct packed {
    logic [1:0]    idx;
    logic [RW-1:0] data;
  } exp_t;

  typedef struct {
    int pat;
    int mode;
    bit extra;
    int exp_rows;
    int exp_en;
    int exp_done;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   en_total = 0, done_total = 0, hs_total = 0;
  int   en_base = 0;
  int   first_valid_cyc = -1, done_cyc = -1, start_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data = '0;
  logic [1:0]    prev_idx = '0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle observation at the falling edge
  task automatic monitor();
    exp_t e;
    logic exp_en;
    chk("wren_eq_en", arr_wren, arr_en);
    exp_en = busy && (!row_valid || row_ready) && ((en_total - en_base) < DIM);
    chk("arr_en", arr_en, exp_en);
    if (prev_stall) begin
      chk("hold_valid", row_valid, 1'b1);
      chk("hold_data", row_data, prev_data);
      chk("hold_idx", row_idx, prev_idx);
    end
    prev_stall = row_valid && !row_ready && !rst;
    prev_data  = row_data;
    prev_idx   = row_idx;
    if (row_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (row_valid && row_ready && !rst) begin
      hs_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got idx %0d data %0h expected none", row_idx, row_data);
      end else begin
        e = exp_q.pop_front();
        chk("row_idx", row_idx, e.idx);
        chk("row_data", row_data, e.data);
      end
    end
    if (arr_en) en_total++;
    if (done) begin
      done_total++;
      done_cyc = cyc;
      chk("busy_in_done", busy, 1'b0);
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Preload the array model and build the expected row stream
  task automatic fill(input int pat);
    logic [BW-1:0] ext [4];
    exp_t e;
    ext[0] = 16'h8000; ext[1] = 16'h7FFF; ext[2] = 16'hFFFF; ext[3] = 16'h0000;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++)
        case (pat)
          0:       load_val[r][j] = BW'((j + 1) * r);
          1:       load_val[r][j] = ext[(j + r) % 4];
          default: load_val[r][j] = BW'($urandom);
        endcase
    exp_q.delete();
    for (int r = DIM - 1; r >= 0; r--) begin
      e.idx = 2'(r);
      for (int j = 0; j < DIM; j++) e.data[j*BW +: BW] = load_val[r][j];
      exp_q.push_back(e);
    end
    load_req = 1'b1;
    cycle();
    load_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  hs_b, dn_b, stall;
    bit  fin;
    fill(v.pat);
    en_base = en_total; hs_b = hs_total; dn_b = done_total;
    first_valid_cyc = -1; stall = -1; fin = 1'b0;
    start = 1'b1; row_ready = 1'b1; start_cyc = cyc;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 80 && !fin; k++) begin
      if (done) fin = 1'b1;
      start = v.extra && (k == 2 || done);
      case (v.mode)
        0: row_ready = 1'b1;
        1: row_ready = ~row_ready;
        2: row_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (row_valid && stall < 0) stall = 3;
          if (stall > 0) begin row_ready = 1'b0; stall--; end
          else row_ready = 1'b1;
        end
      endcase
      cycle();
    end
    start = 1'b0;
    row_ready = 1'b1;
    chk("done_seen", RW'(fin), RW'(1));
    for (int k = 0; k < 3; k++) cycle();
    chk("rows", RW'(hs_total - hs_b), RW'(v.exp_rows));
    chk("en_pulses", RW'(en_total - en_base), RW'(v.exp_en));
    chk("done_pulses", RW'(done_total - dn_b), RW'(v.exp_done));
    chk("rows_left", RW'(exp_q.size()), RW'(0));
    chk("busy_after", busy, 1'b0);
    if (v.mode == 0 && !v.extra) begin
      chk("first_valid_lat", RW'(first_valid_cyc - start_cyc), RW'(2));
      chk("done_lat", RW'(done_cyc - start_cyc), RW'(6));
    end
    if (v.mode == 3) chk("stall_done_lat", RW'(done_cyc - start_cyc), RW'(9));
  endtask

  vec_t vecs[7];

  initial begin
    int hs_b;
    vecs[0] = '{0, 0, 1'b0, 4, 4, 1};
    vecs[1] = '{0, 3, 1'b0, 4, 4, 1};
    vecs[2] = '{0, 0, 1'b1, 4, 4, 1};
    vecs[3] = '{1, 0, 1'b0, 4, 4, 1};
    vecs[4] = '{2, 1, 1'b0, 4, 4, 1};
    vecs[5] = '{2, 2, 1'b0, 4, 4, 1};
    vecs[6] = '{1, 2, 1'b1, 4, 4, 1};

    rst = 1'b1; start = 1'b0; row_ready = 1'b0; load_req = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) load_val[r][j] = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_valid", row_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_en", arr_en, 1'b0);
    chk("rst_data", row_data, '0);
    chk("rst_idx", row_idx, '0);
    rst = 1'b0;
    cycle();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset after the second handshake
    fill(0);
    en_base = en_total; hs_b = hs_total;
    start = 1'b1; row_ready = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 20 && (hs_total - hs_b) < 2; k++) cycle();
    chk("pre_rst_rows", RW'(hs_total - hs_b), RW'(2));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", row_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_en", arr_en, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    exp_q.delete();
    cycle();

    // start coinciding with rst is ignored
    rst = 1'b1; start = 1'b1;
    cycle();
    rst = 1'b0; start = 1'b0;
    cycle();
    chk("start_with_rst_busy", busy, 1'b0);
    chk("start_with_rst_en", arr_en, 1'b0);

    // Fresh drain after reset restarts at row_idx DIM-1
    run_vec(vecs[0]);
    for (int n = 0; n < 6; n++) run_vec('{2, 2, n[0], 4, 4, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_tpu_c_drain
`default_nettype wire
